// File: rtl/nombre_pkg.sv
// Shared constants for the name display path: segment glyphs (gfedcba, active-low),
// the "unknown" letter code and the tracker's per-symbol event classification.
package nombre_pkg;

   localparam int NAME_LEN = 8;

   localparam logic [6:0] PAT_0     = 7'b1000001;
   localparam logic [6:0] PAT_1     = 7'b1111001;
   localparam logic [6:0] PAT_2     = 7'b1000110;
   localparam logic [6:0] PAT_3     = 7'b1001110;
   localparam logic [6:0] PAT_4     = 7'b1000000;
   localparam logic [6:0] PAT_5     = 7'b0101111;
   localparam logic [6:0] PAT_6     = 7'b1111001;
   localparam logic [6:0] PAT_7     = 7'b0001000;
   localparam logic [6:0] PAT_BLANK = 7'b1111111;

   localparam logic [3:0] BCD_NONE = 4'hF;

   typedef enum logic [1:0] {
      EV_IDLE,
      EV_UNKNOWN,
      EV_IN_ORDER,
      EV_OUT_OF_ORDER
   } rx_event_t;

   function automatic logic [6:0] pat_of(input logic [2:0] idx);
      logic [6:0] p;
      case (idx)
         3'd0:    p = PAT_0;
         3'd1:    p = PAT_1;
         3'd2:    p = PAT_2;
         3'd3:    p = PAT_3;
         3'd4:    p = PAT_4;
         3'd5:    p = PAT_5;
         3'd6:    p = PAT_6;
         default: p = PAT_7;
      endcase
      return p;
   endfunction

   function automatic logic [2:0] lowest_idx(input logic [7:0] mask);
      logic [2:0] r;
      r = 3'd0;
      for (int i = NAME_LEN - 1; i >= 0; i--) begin
         if (mask[i]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/nombre_lookup.sv
// Combinational glyph matcher: flags every letter index whose pattern equals seg.
// Indices 1 and 6 share a glyph, so cand may carry two bits.
module nombre_lookup
   import nombre_pkg::*;
(
   input  logic [6:0] seg,
   output logic [7:0] cand,
   output logic       blank
);

   always_comb begin
      cand = '0;
      for (int i = 0; i < NAME_LEN; i++) begin
         cand[i] = (seg == pat_of(3'(i)));
      end
      blank = (seg == PAT_BLANK);
   end

endmodule

// File: rtl/nombre_receptor.sv
// Recovers letter indices from a 7-segment stream and tracks name order.
// Two stages: registered glyph lookup, then the position tracker (pos is its state).
module nombre_receptor
   import nombre_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg,
   input  logic       seg_valid,
   output logic [3:0] bcd,
   output logic       bcd_valid,
   output logic       error,
   output logic       name_done,
   output logic [2:0] pos,
   output logic [7:0] names_ok
);

   localparam logic [2:0] LAST_POS = 3'(NAME_LEN - 1);

   logic [7:0] cand_c;
   logic       blank_c;
   logic [7:0] cand;
   logic       blank;
   logic       vld;
   rx_event_t  ev;

   nombre_lookup u_lookup (
      .seg   (seg),
      .cand  (cand_c),
      .blank (blank_c)
   );

   // seg is taken whenever seg_valid is high on a rising edge; there is no
   // ready, so the receiver must accept one symbol per cycle unconditionally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand  <= '0;
         blank <= 1'b0;
         vld   <= 1'b0;
      end else begin
         vld   <= seg_valid;
         cand  <= seg_valid ? cand_c : '0;
         blank <= seg_valid & blank_c;
      end
   end

   always_comb begin
      ev = EV_IDLE;
      if (vld && !blank) begin
         if (cand == '0)     ev = EV_UNKNOWN;
         else if (cand[pos]) ev = EV_IN_ORDER;
         else                ev = EV_OUT_OF_ORDER;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd       <= BCD_NONE;
         bcd_valid <= 1'b0;
         error     <= 1'b0;
         name_done <= 1'b0;
         pos       <= 3'd0;
         names_ok  <= 8'd0;
      end else begin
         bcd_valid <= 1'b0;
         error     <= 1'b0;
         name_done <= 1'b0;
         case (ev)
            EV_UNKNOWN: begin
               bcd       <= BCD_NONE;
               bcd_valid <= 1'b1;
               error     <= 1'b1;
               pos       <= 3'd0;
            end
            EV_IN_ORDER: begin
               bcd       <= {1'b0, pos};
               bcd_valid <= 1'b1;
               if (pos == LAST_POS) begin
                  name_done <= 1'b1;
                  if (names_ok != 8'hFF) names_ok <= names_ok + 8'd1;
                  pos <= 3'd0;
               end else begin
                  pos <= pos + 3'd1;
               end
            end
            EV_OUT_OF_ORDER: begin
               // A stray letter 0 is treated as the start of a fresh name.
               bcd       <= {1'b0, lowest_idx(cand)};
               bcd_valid <= 1'b1;
               error     <= 1'b1;
               pos       <= cand[0] ? 3'd1 : 3'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nombre_receptor.sv
// Self-checking bench for nombre_receptor: scenario tasks plus a cycle scoreboard
// fed by a behavioural model of the letter/order rules.
module tb_nombre_receptor;

   logic       clk;
   logic       rst;
   logic [6:0] seg;
   logic       seg_valid;
   logic [3:0] bcd;
   logic       bcd_valid;
   logic       error;
   logic       name_done;
   logic [2:0] pos;
   logic [7:0] names_ok;

   localparam logic [6:0] BLANK = 7'b1111111;
   logic [6:0] pat [8] = '{7'b1000001, 7'b1111001, 7'b1000110, 7'b1001110,
                           7'b1000000, 7'b0101111, 7'b1111001, 7'b0001000};

   int n_checks = 0;
   int n_fail   = 0;

   // model state and expected record {bcd, bcd_valid, error, name_done, pos, names_ok}
   int         m_pos;
   int         m_names;
   logic [3:0] m_bcd;
   logic [17:0] exp_q[$];

   nombre_receptor dut (
      .clk       (clk),
      .rst       (rst),
      .seg       (seg),
      .seg_valid (seg_valid),
      .bcd       (bcd),
      .bcd_valid (bcd_valid),
      .error     (error),
      .name_done (name_done),
      .pos       (pos),
      .names_ok  (names_ok)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_push(input logic v, input logic [6:0] s);
      logic bv, er, nd;
      int first;
      bv = 1'b0; er = 1'b0; nd = 1'b0; first = -1;
      for (int i = 7; i >= 0; i--) if (pat[i] == s) first = i;
      if (v && s != BLANK) begin
         bv = 1'b1;
         if (first < 0) begin
            m_bcd = 4'hF; er = 1'b1; m_pos = 0;
         end else if (pat[m_pos] == s) begin
            m_bcd = 4'(m_pos);
            if (m_pos == 7) begin
               nd = 1'b1;
               if (m_names < 255) m_names++;
               m_pos = 0;
            end else begin
               m_pos++;
            end
         end else begin
            m_bcd = 4'(first); er = 1'b1;
            m_pos = (first == 0) ? 1 : 0;
         end
      end
      exp_q.push_back({m_bcd, bv, er, nd, 3'(m_pos), 8'(m_names)});
   endtask

   // Drive one cycle; outputs seen now belong to the symbol driven two cycles ago.
   task automatic cycle(input logic v, input logic [6:0] s);
      logic [17:0] got, exp;
      @(negedge clk);
      got = {bcd, bcd_valid, error, name_done, pos, names_ok};
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("FAIL scoreboard at %0t: got bcd=%h v=%b e=%b d=%b pos=%0d n=%0d, expected bcd=%h v=%b e=%b d=%b pos=%0d n=%0d",
                     $time, got[17:14], got[13], got[12], got[11], got[10:8], got[7:0],
                     exp[17:14], exp[13], exp[12], exp[11], exp[10:8], exp[7:0]);
         end
      end
      seg_valid = v;
      seg       = s;
      model_push(v, s);
   endtask

   task automatic send_idx(input int idx);
      cycle(1'b1, pat[idx]);
   endtask

   task automatic send_name();
      for (int i = 0; i < 8; i++) send_idx(i);
   endtask

   task automatic flush();
      cycle(1'b0, BLANK);
      cycle(1'b0, BLANK);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; seg_valid = 1'b0; seg = BLANK;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_pos = 0; m_names = 0; m_bcd = 4'hF;
      exp_q.delete();
      model_push(1'b0, BLANK);
      model_push(1'b0, BLANK);
   endtask

   task automatic test_reset();
      n_checks++; if (bcd !== 4'hF)     begin n_fail++; $display("FAIL reset_bcd: got %h expected f", bcd); end
      n_checks++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bcd_valid: got %b expected 0", bcd_valid); end
      n_checks++; if (error !== 1'b0)   begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
      n_checks++; if (name_done !== 1'b0) begin n_fail++; $display("FAIL reset_name_done: got %b expected 0", name_done); end
      n_checks++; if (pos !== 3'd0)     begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", pos); end
      n_checks++; if (names_ok !== 8'd0) begin n_fail++; $display("FAIL reset_names_ok: got %0d expected 0", names_ok); end
   endtask

   task automatic test_in_order();
      logic err_seen;
      err_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send_idx(i);
         err_seen |= error;
      end
      flush();
      err_seen |= error;
      n_checks++; if (bcd !== 4'd7)      begin n_fail++; $display("FAIL in_order_bcd: got %0d expected 7", bcd); end
      n_checks++; if (name_done !== 1'b1) begin n_fail++; $display("FAIL in_order_name_done: got %b expected 1", name_done); end
      n_checks++; if (names_ok !== 8'd1) begin n_fail++; $display("FAIL in_order_names_ok: got %0d expected 1", names_ok); end
      n_checks++; if (pos !== 3'd0)      begin n_fail++; $display("FAIL in_order_pos: got %0d expected 0", pos); end
      n_checks++; if (err_seen !== 1'b0) begin n_fail++; $display("FAIL in_order_no_error: got %b expected 0", err_seen); end
   endtask

   task automatic test_ambiguity();
      for (int i = 0; i < 7; i++) send_idx(i);
      flush();
      n_checks++; if (bcd !== 4'd6)    begin n_fail++; $display("FAIL amb_pos6_bcd: got %0d expected 6", bcd); end
      n_checks++; if (error !== 1'b0)  begin n_fail++; $display("FAIL amb_pos6_error: got %b expected 0", error); end
      n_checks++; if (pos !== 3'd7)    begin n_fail++; $display("FAIL amb_pos6_pos: got %0d expected 7", pos); end
      send_idx(7);
      flush();
      apply_reset();
      cycle(1'b1, 7'b1111001);
      flush();
      n_checks++; if (bcd !== 4'd1)    begin n_fail++; $display("FAIL amb_first_bcd: got %0d expected 1", bcd); end
      n_checks++; if (error !== 1'b1)  begin n_fail++; $display("FAIL amb_first_error: got %b expected 1", error); end
      n_checks++; if (pos !== 3'd0)    begin n_fail++; $display("FAIL amb_first_pos: got %0d expected 0", pos); end
   endtask

   task automatic test_gaps();
      int valid_cnt;
      valid_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, BLANK);
         valid_cnt += int'(bcd_valid);
         cycle(1'b0, 7'($urandom));
         valid_cnt += int'(bcd_valid);
         send_idx(i);
         valid_cnt += int'(bcd_valid);
      end
      flush();
      valid_cnt += int'(bcd_valid);
      n_checks++; if (name_done !== 1'b1) begin n_fail++; $display("FAIL gaps_name_done: got %b expected 1", name_done); end
      n_checks++; if (valid_cnt !== 8)    begin n_fail++; $display("FAIL gaps_pulse_count: got %0d expected 8", valid_cnt); end
      cycle(1'b1, 7'b0000000);
      flush();
      n_checks++; if (bcd !== 4'hF)    begin n_fail++; $display("FAIL unknown_bcd: got %h expected f", bcd); end
      n_checks++; if (error !== 1'b1)  begin n_fail++; $display("FAIL unknown_error: got %b expected 1", error); end
      n_checks++; if (pos !== 3'd0)    begin n_fail++; $display("FAIL unknown_pos: got %0d expected 0", pos); end
   endtask

   task automatic test_resync();
      send_idx(0); send_idx(1); send_idx(2); send_idx(0);
      flush();
      n_checks++; if (error !== 1'b1)  begin n_fail++; $display("FAIL resync_error: got %b expected 1", error); end
      n_checks++; if (bcd !== 4'd0)    begin n_fail++; $display("FAIL resync_bcd: got %0d expected 0", bcd); end
      n_checks++; if (pos !== 3'd1)    begin n_fail++; $display("FAIL resync_pos: got %0d expected 1", pos); end
      for (int i = 1; i < 8; i++) send_idx(i);
      flush();
      n_checks++; if (name_done !== 1'b1) begin n_fail++; $display("FAIL resync_name_done: got %b expected 1", name_done); end
   endtask

   task automatic test_back_to_back();
      send_name();
      send_name();
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: send_idx(m_pos);
            6:       cycle(1'b1, BLANK);
            7:       cycle(1'b0, 7'($urandom));
            8:       send_idx($urandom_range(0, 7));
            default: cycle(1'b1, 7'($urandom));
         endcase
      end
      flush();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 5; i++) send_idx(i);
      @(negedge clk);
      rst = 1'b1; seg_valid = 1'b0;
      #1;
      n_checks++; if (bcd !== 4'hF)       begin n_fail++; $display("FAIL midrst_bcd: got %h expected f", bcd); end
      n_checks++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_bcd_valid: got %b expected 0", bcd_valid); end
      n_checks++; if (error !== 1'b0)     begin n_fail++; $display("FAIL midrst_error: got %b expected 0", error); end
      n_checks++; if (pos !== 3'd0)       begin n_fail++; $display("FAIL midrst_pos: got %0d expected 0", pos); end
      apply_reset();
      send_name();
      flush();
      n_checks++; if (name_done !== 1'b1) begin n_fail++; $display("FAIL midrst_name_done: got %b expected 1", name_done); end
      n_checks++; if (names_ok !== 8'd1)  begin n_fail++; $display("FAIL midrst_names_ok: got %0d expected 1", names_ok); end
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int n = 0; n < 255; n++) send_name();
      flush();
      n_checks++; if (names_ok !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d expected 255", names_ok); end
      send_name();
      flush();
      n_checks++; if (name_done !== 1'b1)  begin n_fail++; $display("FAIL sat_name_done: got %b expected 1", name_done); end
      n_checks++; if (names_ok !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", names_ok); end
   endtask

   initial begin
      rst = 1'b1; seg_valid = 1'b0; seg = BLANK;
      m_pos = 0; m_names = 0; m_bcd = 4'hF;
      apply_reset();
      test_reset();
      test_in_order();
      test_ambiguity();
      test_gaps();
      test_resync();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nombre_receptor.md
# nombre_receptor

Receiving end of the name display path. It watches a stream of 7-segment patterns (gfedcba, active-low) as produced by the name segment decoder and recovers the letter index 0–7 for each one. It checks that the letters arrive in name order, and uses the expected position to resolve the one ambiguous pattern (indices 1 and 6 share a glyph). It sits on the verification/loopback side of the display, feeding status LEDs and the self-test counter.

## Interface
Parameters
- None. All patterns are fixed constants in the shared package.

Ports
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- seg  in  7  segment pattern, gfedcba, active-low
- seg_valid  in  1  qualifies seg for one cycle; one symbol may arrive every cycle
- bcd  out  4  recovered letter index 0–7; 4'hF = unknown pattern
- bcd_valid  out  1  one-cycle pulse, bcd is meaningful
- error  out  1  one-cycle pulse: unknown pattern or out-of-order letter
- name_done  out  1  one-cycle pulse: index 7 accepted in order, so the full name was received
- pos  out  3  index expected next
- names_ok  out  8  count of completed names; saturates at 255

## Operation
- Pattern table (index: gfedcba):
  - 0: 1000001
  - 1: 1111001
  - 2: 1000110
  - 3: 1001110
  - 4: 1000000
  - 5: 0101111
  - 6: 1111001
  - 7: 0001000
  - BLANK: 1111111
- Stage 1 (lookup): on seg_valid, register `cand[7:0]`, a one-hot-or-more mask of every index whose pattern equals seg. Also register `blank` (seg == BLANK) and `vld`.
- Stage 2 (tracker) acts only when `vld` = 1.
  - blank = 1: gap. No output pulses; pos unchanged.
  - cand = 0 (unknown pattern):
    - bcd = 4'hF; bcd_valid = 1; error = 1.
    - pos → 0.
  - cand[pos] = 1 (in order):
    - bcd = pos; bcd_valid = 1.
    - If pos = 7: name_done = 1, names_ok increments (saturating), pos → 0.
    - Otherwise pos → pos+1.
  - Otherwise (out of order):
    - bcd = lowest set bit of cand; bcd_valid = 1; error = 1.
    - If cand[0] = 1, the letter is taken as a new start and pos → 1; otherwise pos → 0.
- The ambiguity between 1 and 6 resolves by position: 1111001 at pos 1 gives bcd 1, at pos 6 gives bcd 6, and anywhere else gives bcd 1 with error.
- bcd holds its last value between pulses. error and bcd_valid are never asserted for a blank.

## Timing
- Reset values:
  - bcd = 4'hF
  - bcd_valid = 0, error = 0, name_done = 0
  - pos = 0
  - names_ok = 0
  - internal cand = 0, vld = 0, blank = 0
- Latency: seg/seg_valid sampled at edge N produce bcd/bcd_valid/error/name_done/pos at edge N+1 after lookup, i.e. visible 2 edges after presentation. The block is fully pipelined at 1 symbol per cycle, with no backpressure.
- Back-to-back symbols: the tracker uses the pos updated by the previous symbol. No bubble is required.
- names_ok updates in the same cycle as name_done. At 255 it holds, and name_done still pulses.
- rst asserted mid-name clears pos and drops any symbol in stage 1. The first symbol after release is judged against pos 0.

## Structure
- Shared package `nombre_pkg` holds:
  - PAT_0 … PAT_7 and PAT_BLANK (7-bit)
  - BCD_NONE = 4'hF
  - NAME_LEN = 8
- The decoder side should import the same constants so the two ends cannot diverge.
- Sub-module `nombre_lookup`: purely combinational, seg → cand[7:0] and blank. It is instantiated once, in front of the stage-1 register.
- The tracker FSM lives in the top: pos is the state, plus the names_ok counter. Expected size is about 150 RTL lines.

## Test plan
- In-order name: present patterns 0..7 with seg_valid each cycle.
  - Expect bcd 0,1,2,3,4,5,6,7 on consecutive cycles, starting 2 edges later.
  - name_done on the cycle bcd = 7; names_ok = 1; pos = 0; error never asserted.
- Ambiguity: present 1111001 at pos 6 (after 0..5).
  - Expect bcd = 6, no error.
  - The same pattern as the first symbol after reset gives bcd = 1, error = 1, pos = 0.
- Gaps and unknowns:
  - Name interleaved with BLANK and seg_valid=0 cycles: completes normally, no pulses on blanks.
  - seg = 0000000: bcd = 4'hF, error = 1, pos = 0.
- Resync: send 0,1,2, then pattern 0.
  - Expect error = 1, bcd = 0, pos = 1.
  - Continuing with 1..7 gives name_done.
- Saturation: 256 complete names back-to-back.
  - names_ok = 255 and holds; the 256th name still pulses name_done.
- Reset mid-name: assert rst after 0,1,2,3 with a symbol in flight.
  - All outputs return to reset values at once, no pulse for the in-flight symbol.
  - A fresh 0..7 then completes.
